// File: rtl/fitness_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fitness_pkg : shared types and golden tables for fitness evaluation |
// | Revision    : 1.0                                                   |
// +--------------------------------------------------------------------+
package fitness_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2
    } fit_state_e;

    // Golden tables: bit v is the expected output for input vector v.
    localparam logic [7:0] MUX2_TT = 8'hCA;
    localparam logic [3:0] AND2_TT = 4'h8;
    localparam logic [3:0] XOR2_TT = 4'h6;

    // Enough bits to hold a score of 0 .. 2^n inclusive (i.e. n+1).
    function automatic int score_width(input int n);
        return $clog2((1 << n) + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fitness_settle_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fitness_settle_timer : loadable down-counter with terminal count    |
// | Revision             : 1.0                                          |
// +--------------------------------------------------------------------+
module fitness_settle_timer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    // Loading SETTLE_CYCLES-1 gives exactly SETTLE_CYCLES cycles until o_tc acts.
    localparam logic [CW-1:0] c_load_val = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/truth_table_fitness_eval.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | truth_table_fitness_eval : sweeps all input vectors of a candidate, |
// | scores its output against a golden truth table. Revision: 1.0       |
// +--------------------------------------------------------------------+
module truth_table_fitness_eval
    import fitness_pkg::*;
#(
    parameter int                          N_INPUTS      = 3,
    parameter logic [(1<<N_INPUTS)-1:0]    TRUTH_TABLE   = MUX2_TT,
    parameter int                          SETTLE_CYCLES = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    output logic [N_INPUTS-1:0]                dut_in,
    input  logic                               dut_out,
    output logic                               busy,
    output logic                               done,
    output logic [score_width(N_INPUTS)-1:0]   score,
    output logic                               pass,
    output logic                               fail_seen,
    output logic [N_INPUTS-1:0]                first_fail
);

    localparam int                  SW           = score_width(N_INPUTS);
    localparam logic [SW-1:0]       c_full_score = SW'(1 << N_INPUTS);
    localparam logic [N_INPUTS-1:0] c_last_vec   = {N_INPUTS{1'b1}};

    fit_state_e          r_state;
    logic [N_INPUTS-1:0] r_dut_in;
    logic                r_busy;
    logic                r_done;
    logic [SW-1:0]       r_score;
    logic                r_pass;
    logic                r_fail_seen;
    logic [N_INPUTS-1:0] r_first_fail;

    logic                w_match;
    logic                w_last;
    logic [SW-1:0]       w_score_next;
    logic                w_timer_load;
    logic                w_timer_en;
    logic                w_settled;

    assign w_match      = (dut_out == TRUTH_TABLE[r_dut_in]);
    assign w_last       = (r_dut_in == c_last_vec);
    assign w_score_next = r_score + SW'(w_match);

    // The timer is reloaded whenever a fresh vector enters DRIVE.
    assign w_timer_load = ((r_state == IDLE) && start) || ((r_state == SAMPLE) && !w_last);
    assign w_timer_en   = (r_state == DRIVE);

    fitness_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_timer_load),
        .i_en   (w_timer_en),
        .o_tc   (w_settled)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_dut_in     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_score      <= '0;
            r_pass       <= 1'b0;
            r_fail_seen  <= 1'b0;
            r_first_fail <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dut_in     <= '0;
                        r_score      <= '0;
                        r_pass       <= 1'b0;
                        r_fail_seen  <= 1'b0;
                        r_first_fail <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (w_settled) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_score <= w_score_next;
                    if (!w_match && !r_fail_seen) begin
                        r_fail_seen  <= 1'b1;
                        r_first_fail <= r_dut_in;
                    end
                    if (w_last) begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_pass   <= (w_score_next == c_full_score);
                        r_dut_in <= '0;
                    end else begin
                        r_dut_in <= r_dut_in + N_INPUTS'(1);
                        r_state  <= DRIVE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dut_in     = r_dut_in;
    assign busy       = r_busy;
    assign done       = r_done;
    assign score      = r_score;
    assign pass       = r_pass;
    assign fail_seen  = r_fail_seen;
    assign first_fail = r_first_fail;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_fitness_eval.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_truth_table_fitness_eval : directed checks of the fitness harness|
// | Revision                    : 1.0                                   |
// +--------------------------------------------------------------------+
module tb_truth_table_fitness_eval;
    import fitness_pkg::*;

    logic       clk;
    logic       rst;

    // Instance A: default 3-input mux configuration
    logic       start_a;
    logic [2:0] dut_in_a;
    logic       dut_out_a;
    logic       busy_a, done_a, pass_a, fail_seen_a;
    logic [3:0] score_a;
    logic [2:0] first_fail_a;

    // Instance B: 2-input XOR, longer settle time
    logic       start_b;
    logic [1:0] dut_in_b;
    logic       dut_out_b;
    logic       busy_b, done_b, pass_b, fail_seen_b;
    logic [2:0] score_b;
    logic [1:0] first_fail_b;

    int n_cmp = 0;
    int n_err = 0;
    int mode  = 0;   // 0: correct mux, 1: inverted mux, 2: stuck-at-0

    truth_table_fitness_eval u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start_a),
        .dut_in     (dut_in_a),
        .dut_out    (dut_out_a),
        .busy       (busy_a),
        .done       (done_a),
        .score      (score_a),
        .pass       (pass_a),
        .fail_seen  (fail_seen_a),
        .first_fail (first_fail_a)
    );

    truth_table_fitness_eval #(
        .N_INPUTS      (2),
        .TRUTH_TABLE   (XOR2_TT),
        .SETTLE_CYCLES (3)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start_b),
        .dut_in     (dut_in_b),
        .dut_out    (dut_out_b),
        .busy       (busy_b),
        .done       (done_b),
        .score      (score_b),
        .pass       (pass_b),
        .fail_seen  (fail_seen_b),
        .first_fail (first_fail_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural candidates: vector = {sel, I1, I0}
    always_comb begin
        dut_out_a = 1'b0;
        case (mode)
            0: dut_out_a = dut_in_a[2] ? dut_in_a[1] : dut_in_a[0];
            1: dut_out_a = ~(dut_in_a[2] ? dut_in_a[1] : dut_in_a[0]);
            default: dut_out_a = 1'b0;
        endcase
    end
    assign dut_out_b = dut_in_b[0] ^ dut_in_b[1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_results_a(input string tag, input int sc, input int ps,
                                   input int fs, input int ff);
        check_eq({tag, "_score"},      score_a,      sc);
        check_eq({tag, "_pass"},       pass_a,       ps);
        check_eq({tag, "_fail_seen"},  fail_seen_a,  fs);
        check_eq({tag, "_first_fail"}, first_fail_a, ff);
    endtask

    // Start a run on instance A and wait (bounded) for done; expect 16-cycle latency.
    task automatic run_a(input string tag);
        int cyc;
        bit seen;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        check_eq({tag, "_busy"}, busy_a, 1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_a) seen = 1'b1;
        end
        check_eq({tag, "_latency"}, cyc, 16);
        check_eq({tag, "_busy_at_done"}, busy_a, 0);
        check_eq({tag, "_dut_in_at_done"}, dut_in_a, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_cmp %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        int done_c1;
        int done_c2;
        int first_done;

        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy",      busy_a,       0);
        check_eq("rst_done",      done_a,       0);
        check_eq("rst_dut_in",    dut_in_a,     0);
        check_results_a("rst", 0, 0, 0, 0);
        check_eq("rst_b_score",   score_b,      0);
        @(negedge clk);
        rst = 1'b0;

        // Correct mux
        mode = 0;
        run_a("mux");
        check_results_a("mux", 8, 1, 0, 0);
        @(posedge clk);
        #1 check_eq("mux_done_width", done_a, 0);

        // Inverted mux
        mode = 1;
        run_a("inv");
        check_results_a("inv", 0, 0, 1, 0);

        // Stuck-at-0: rows 0,2,4,5 match
        mode = 2;
        run_a("sa0");
        check_results_a("sa0", 4, 0, 1, 1);

        // Start while busy ignored; start in done cycle accepted
        mode = 0;
        done_cnt = 0;
        done_c1  = 0;
        done_c2  = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
            if (done_a) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_c1 = c;
                    check_eq("b2b_first_score", score_a, 8);
                end else begin
                    done_c2 = c;
                end
            end
            if (c == 5) start_a = 1'b1;
            if (done_a && done_cnt == 1) start_a = 1'b1;
        end
        check_eq("b2b_done_count", done_cnt, 2);
        check_eq("b2b_first_done", done_c1, 16);
        check_eq("b2b_second_done", done_c2, 33);
        check_results_a("b2b_second", 8, 1, 0, 0);

        // Async reset mid-run (stuck-at-0 so partial state is non-zero)
        mode = 2;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check_eq("midrun_pre_score", score_a, 2);
        check_eq("midrun_pre_dut_in", dut_in_a, 3);
        rst = 1'b1;
        #1;
        check_eq("midrun_rst_busy",   busy_a,   0);
        check_eq("midrun_rst_dut_in", dut_in_a, 0);
        check_eq("midrun_rst_done",   done_a,   0);
        check_results_a("midrun_rst", 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done_a) done_cnt++;
        end
        check_eq("midrun_no_done", done_cnt, 0);
        check_eq("midrun_idle_busy", busy_a, 0);
        mode = 0;
        run_a("post_rst");
        check_results_a("post_rst", 8, 1, 0, 0);

        // Instance B: XOR, SETTLE_CYCLES=3, each vector held 4 cycles
        first_done = 0;
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        check_eq("xor_dut_in_j0", dut_in_b, 0);
        check_eq("xor_busy", busy_b, 1);
        for (int j = 1; j <= 16; j++) begin
            @(posedge clk);
            #1;
            if (done_b && first_done == 0) first_done = j;
            if (j < 16) check_eq($sformatf("xor_dut_in_j%0d", j), dut_in_b, j / 4);
        end
        check_eq("xor_done_cycle", first_done, 16);
        check_eq("xor_score",      score_b,     4);
        check_eq("xor_pass",       pass_b,      1);
        check_eq("xor_fail_seen",  fail_seen_b, 0);
        check_eq("xor_first_fail", first_fail_b, 0);
        check_eq("xor_dut_in_end", dut_in_b,    0);
        @(posedge clk);
        #1 check_eq("xor_done_width", done_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/truth_table_fitness_eval.md
Name: truth_table_fitness_eval

Overview:
- Sequential test harness that sits around an evolved gate-level candidate circuit, such as the evolved 2:1 mux.
- Upstream role: drives every input combination onto the candidate.
- Downstream role: samples the candidate's single output and compares it against a golden truth table.
- Accumulates a fitness score (count of matching rows) plus first-failure diagnostics for the GP fitness loop.

Parameters:
- N_INPUTS, 3: number of candidate inputs; 2^N_INPUTS vectors are evaluated per run.
- TRUTH_TABLE, 8'hCA: golden output, bit v = expected output for input vector v. The default is the 2:1 mux with vector = {sel, I1, I0}. Width is 2^N_INPUTS.
- SETTLE_CYCLES, 1: cycles each vector is held before sampling. Range ≥ 1.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: request an evaluation run; honoured only when not busy.
- dut_in, output, N_INPUTS: vector applied to the candidate; bit 0 = I0, bit 1 = I1, bit 2 = sel for the default.
- dut_out, input, 1: candidate output (combinational from dut_in).
- busy, output, 1: high while a run is in progress.
- done, output, 1: one-cycle pulse when a run completes.
- score, output, N_INPUTS+1: number of vectors where dut_out matched TRUTH_TABLE.
- pass, output, 1: score == 2^N_INPUTS.
- fail_seen, output, 1: at least one mismatch in the last run.
- first_fail, output, N_INPUTS: lowest vector index that mismatched; 0 when fail_seen = 0.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE.
  - dut_in, busy, done, score, pass, fail_seen, first_fail and the internal settle counter are all 0.
  - Takes effect immediately, including mid-run. The partial run is discarded and no done pulse is issued.
- States: IDLE, DRIVE, SAMPLE.
- IDLE:
  - On a rising edge with start=1: dut_in <= 0, settle counter <= 0, score/fail_seen/first_fail/pass <= 0, busy <= 1, state <= DRIVE.
  - Previous results are held until this edge.
- DRIVE:
  - dut_in held constant; settle counter increments each cycle.
  - After SETTLE_CYCLES cycles in DRIVE, state <= SAMPLE.
- SAMPLE (one cycle):
  - match = (dut_out == TRUTH_TABLE[dut_in]); score += match.
  - On the first mismatch: fail_seen <= 1, first_fail <= dut_in. Later mismatches do not change first_fail.
  - If dut_in != 2^N_INPUTS-1: dut_in += 1, settle counter <= 0, state <= DRIVE.
  - Otherwise (last vector):
    - state <= IDLE, busy <= 0, done <= 1.
    - pass <= (final score == 2^N_INPUTS), computed including the current row's match.
    - dut_in returns to 0.
- Timing: each vector occupies SETTLE_CYCLES+1 cycles. If start is captured at edge k, vector v is sampled at edge k+(v+1)(SETTLE_CYCLES+1). For defaults, done is high in the cycle after edge k+16.
- done is registered, high for exactly one cycle.
- start while busy: ignored.
- start in the same cycle that done is high: accepted; a back-to-back run begins.
- Arithmetic: score is N_INPUTS+1 bits and never wraps, max 2^N_INPUTS. dut_in does not wrap within a run.
- dut_out is only examined in SAMPLE; glitches in DRIVE are ignored.

Decomposition:
- Shared package fitness_pkg contains:
  - state enum {IDLE, DRIVE, SAMPLE};
  - constant MUX2_TT = 8'hCA, plus other golden tables used by the GP flow (AND2 = 4'h8, XOR2 = 4'h6);
  - the score-width function clog2-based N_INPUTS+1.
- One natural sub-module, fitness_settle_timer: loadable down-counter with a terminal-count flag, parameterised by SETTLE_CYCLES.
- Comparison and score logic stay in the top module.

Test Plan:
- Correct behavioural 2:1 mux on dut_out, start pulse → after 16 cycles done=1, score=8, pass=1, fail_seen=0, first_fail=0.
- dut_out = ~mux (inverted) → score=0, pass=0, fail_seen=1, first_fail=0.
- dut_out stuck-at-0 → score=4 (rows 0,2,4,5 match), fail_seen=1, first_fail=1.
- start re-asserted at cycle 5 of a run → ignored; done exactly once at cycle 16; second start in the done cycle → second run completes 16 cycles later with identical score.
- rst pulsed at cycle 7 of a run → all outputs 0 immediately, no done pulse; fresh start → full correct run.
- N_INPUTS=2, TRUTH_TABLE=4'h6, dut_out = XOR, SETTLE_CYCLES=3 → done after 16 cycles, score=3'd4, pass=1; dut_in steps 0→3, each held 4 cycles.
